// File: rtl/plat_collide_seq.sv
// plat_collide_seq: sequential landing search that scans one platform per cycle
// and reports the highest surface crossed by the character's feet this frame.
module plat_collide_seq #(
  parameter int PLATFORM_NUM_PER_BLOCK = 7,
  parameter int PHY_WIDTH = 14,
  parameter int BLOCK_LEN_WIDTH = 4,
  parameter int TILE_WIDTH = 8,
  parameter int CHAR_WIDTH = 16
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic start,
  input  logic abort,
  input  logic [PHY_WIDTH-1:0] char_x,
  input  logic [PHY_WIDTH-1:0] char_y_cur,
  input  logic [PHY_WIDTH-1:0] char_y_next,
  input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0] plat_relative_x,
  input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0] plat_relative_y,
  input  logic [PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH-1:0] plat_len,
  output logic busy,
  output logic done,
  output logic hit,
  output logic aborted,
  output logic [PHY_WIDTH-1:0] land_y,
  output logic [2:0] land_idx
);
  localparam int N = PLATFORM_NUM_PER_BLOCK;
  localparam int W = PHY_WIDTH;
  localparam int BL = BLOCK_LEN_WIDTH;
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d, best_idx_q, best_idx_d, land_idx_q, land_idx_d;
  logic [W-1:0] cx_q, cx_d, ycur_q, ycur_d, ynext_q, ynext_d, best_y_q, best_y_d, land_y_q, land_y_d;
  logic [N*W-1:0] pxa_q, pxa_d, pya_q, pya_d;
  logic [N*BL-1:0] lena_q, lena_d;
  logic best_hit_q, best_hit_d, busy_q, busy_d, done_q, done_d, hit_q, hit_d, aborted_q, aborted_d;
  logic [W-1:0] px, py;
  logic [BL-1:0] len;
  logic [W:0] p_end, c_end;
  logic cand, better, nb_hit;
  logic [W-1:0] nb_y;
  logic [2:0] nb_idx;
  assign px = pxa_q[idx_q*W +: W];
  assign py = pya_q[idx_q*W +: W];
  assign len = lena_q[idx_q*BL +: BL];
  // Extra bit keeps the right-edge sums from wrapping near the top of the range.
  assign p_end = {1'b0, px} + (W+1)'(len) * (W+1)'(TILE_WIDTH);
  assign c_end = {1'b0, cx_q} + (W+1)'(CHAR_WIDTH);
  assign cand = (len != '0) && ({1'b0, cx_q} < p_end) && (c_end > {1'b0, px}) && (ynext_q <= py) && (py <= ycur_q);
  // Strict compare keeps the lower index on equal surfaces.
  assign better = cand && (!best_hit_q || py > best_y_q);
  assign nb_hit = better | best_hit_q;
  assign nb_y = better ? py : best_y_q;
  assign nb_idx = better ? idx_q : best_idx_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cx_d = cx_q;
    ycur_d = ycur_q;
    ynext_d = ynext_q;
    pxa_d = pxa_q;
    pya_d = pya_q;
    lena_d = lena_q;
    best_hit_d = best_hit_q;
    best_y_d = best_y_q;
    best_idx_d = best_idx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    hit_d = hit_q;
    aborted_d = aborted_q;
    land_y_d = land_y_q;
    land_idx_d = land_idx_q;
    if (state_q == IDLE) begin
      if (start && !abort) begin
        state_d = SCAN;
        idx_d = '0;
        cx_d = char_x;
        ycur_d = char_y_cur;
        ynext_d = char_y_next;
        pxa_d = plat_relative_x;
        pya_d = plat_relative_y;
        lena_d = plat_len;
        best_hit_d = 1'b0;
        best_y_d = '0;
        best_idx_d = '0;
        busy_d = 1'b1;
      end
    end else if (abort) begin
      state_d = IDLE;
      busy_d = 1'b0;
      done_d = 1'b1;
      aborted_d = 1'b1;
      hit_d = 1'b0;
      land_y_d = '0;
      land_idx_d = '0;
    end else begin
      best_hit_d = nb_hit;
      best_y_d = nb_y;
      best_idx_d = nb_idx;
      idx_d = idx_q + 3'd1;
      if (idx_q == 3'(N-1)) begin
        state_d = IDLE;
        busy_d = 1'b0;
        done_d = 1'b1;
        aborted_d = 1'b0;
        hit_d = nb_hit;
        land_y_d = nb_y;
        land_idx_d = nb_idx;
      end
    end
  end
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      cx_q <= '0;
      ycur_q <= '0;
      ynext_q <= '0;
      pxa_q <= '0;
      pya_q <= '0;
      lena_q <= '0;
      best_hit_q <= 1'b0;
      best_y_q <= '0;
      best_idx_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hit_q <= 1'b0;
      aborted_q <= 1'b0;
      land_y_q <= '0;
      land_idx_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cx_q <= cx_d;
      ycur_q <= ycur_d;
      ynext_q <= ynext_d;
      pxa_q <= pxa_d;
      pya_q <= pya_d;
      lena_q <= lena_d;
      best_hit_q <= best_hit_d;
      best_y_q <= best_y_d;
      best_idx_q <= best_idx_d;
      busy_q <= busy_d;
      done_q <= done_d;
      hit_q <= hit_d;
      aborted_q <= aborted_d;
      land_y_q <= land_y_d;
      land_idx_q <= land_idx_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign hit = hit_q;
  assign aborted = aborted_q;
  assign land_y = land_y_q;
  assign land_idx = land_idx_q;
endmodule

// File: tb/tb_plat_collide_seq.sv
// tb_plat_collide_seq: directed checks of the sequential platform landing search.
module tb_plat_collide_seq;
  logic sys_clk = 1'b0;
  logic sys_rst_n, start, abort, busy, done, hit, aborted;
  logic [13:0] char_x, char_y_cur, char_y_next, land_y;
  logic [97:0] plat_relative_x, plat_relative_y;
  logic [27:0] plat_len;
  logic [2:0] land_idx;
  logic [13:0] tpx [7];
  logic [13:0] tpy [7];
  logic [3:0] tpl [7];
  int tests = 0;
  int fails = 0;
  always #5 sys_clk = ~sys_clk;
  always_comb begin
    plat_relative_x = '0;
    plat_relative_y = '0;
    plat_len = '0;
    for (int i = 0; i < 7; i++) begin
      plat_relative_x[i*14 +: 14] = tpx[i];
      plat_relative_y[i*14 +: 14] = tpy[i];
      plat_len[i*4 +: 4] = tpl[i];
    end
  end
  plat_collide_seq dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .abort(abort),
    .char_x(char_x), .char_y_cur(char_y_cur), .char_y_next(char_y_next),
    .plat_relative_x(plat_relative_x), .plat_relative_y(plat_relative_y), .plat_len(plat_len),
    .busy(busy), .done(done), .hit(hit), .aborted(aborted), .land_y(land_y), .land_idx(land_idx)
  );
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic clear_plats();
    for (int i = 0; i < 7; i++) begin
      tpx[i] = 14'd1000;
      tpy[i] = 14'd1000;
      tpl[i] = 4'd1;
    end
  endtask
  task automatic scan(input string tag);
    logic early;
    early = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    repeat (6) begin
      tick();
      early |= done | ~busy;
    end
    chk({tag, "_early"}, early, 0);
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_off"}, busy, 0);
  endtask
  task automatic res(input string tag, input logic h, input logic [13:0] y, input logic [2:0] idx);
    chk({tag, "_hit"}, hit, h);
    chk({tag, "_land_y"}, land_y, y);
    chk({tag, "_land_idx"}, land_idx, idx);
    chk({tag, "_aborted"}, aborted, 0);
  endtask
  initial begin
    logic seen;
    sys_rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    char_x = '0;
    char_y_cur = '0;
    char_y_next = '0;
    clear_plats();
    tick();
    tick();
    sys_rst_n = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hit", hit, 0);
    chk("rst_land_y", land_y, 0);
    // single landing on idx0
    tpx[0] = 14'd280; tpy[0] = 14'd60; tpl[0] = 4'd10;
    char_x = 14'd300; char_y_cur = 14'd64; char_y_next = 14'd58;
    scan("single");
    res("single", 1, 60, 0);
    tick();
    chk("done_one_cycle", done, 0);
    chk("hold_hit", hit, 1);
    // two candidates, higher surface wins
    clear_plats();
    tpx[2] = 14'd280; tpy[2] = 14'd140; tpl[2] = 4'd4;
    tpx[5] = 14'd290; tpy[5] = 14'd135; tpl[5] = 4'd2;
    char_x = 14'd300; char_y_cur = 14'd145; char_y_next = 14'd130;
    scan("two");
    res("two", 1, 140, 2);
    tpy[5] = 14'd140;
    scan("tie");
    res("tie", 1, 140, 2);
    tpy[5] = 14'd142;
    scan("later_higher");
    res("later_higher", 1, 142, 5);
    // horizontal edge cases around idx3 at x=50, len 2 -> right edge 66
    clear_plats();
    tpx[3] = 14'd50; tpy[3] = 14'd20; tpl[3] = 4'd2;
    char_y_cur = 14'd25; char_y_next = 14'd15;
    char_x = 14'd0;
    scan("x0");
    res("x0", 0, 0, 0);
    char_x = 14'd34;
    scan("x34");
    res("x34", 0, 0, 0);
    char_x = 14'd35;
    scan("x35");
    res("x35", 1, 20, 3);
    char_x = 14'd66;
    scan("x66");
    res("x66", 0, 0, 0);
    char_x = 14'd65;
    scan("x65");
    res("x65", 1, 20, 3);
    char_y_next = 14'd21;
    scan("y_above");
    res("y_above", 0, 0, 0);
    char_y_next = 14'd15;
    tpl[3] = 4'd0;
    scan("len0");
    res("len0", 0, 0, 0);
    // abort at k+3 after a hit result is on the outputs
    tpl[3] = 4'd2;
    scan("pre_abort");
    res("pre_abort", 1, 20, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_done", done, 1);
    chk("abort_flag", aborted, 1);
    chk("abort_hit", hit, 0);
    chk("abort_busy", busy, 0);
    chk("abort_land_y", land_y, 0);
    chk("abort_land_idx", land_idx, 0);
    tick();
    chk("abort_done_drop", done, 0);
    chk("abort_hold", aborted, 1);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle_busy", busy, 0);
    tick();
    chk("start_abort_idle_done", done, 0);
    // restarts while busy are ignored; start during done is accepted
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    tick();
    seen |= done;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen |= done;
    tick();
    seen |= done;
    tick();
    seen |= done;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen |= done;
    tick();
    seen |= done;
    chk("hs_no_early_done", seen, 0);
    tick();
    chk("hs_done_k7", done, 1);
    chk("hs_clear_aborted", aborted, 0);
    chk("hs_hit", hit, 1);
    char_x = 14'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_done_low", done, 0);
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen |= done;
    end
    chk("b2b_no_early", seen, 0);
    tick();
    chk("b2b_done", done, 1);
    chk("b2b_hit", hit, 0);
    // reset mid-scan after a hit is latched
    char_x = 14'd35;
    scan("pre_rst");
    res("pre_rst", 1, 20, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_hit", hit, 0);
    chk("mrst_aborted", aborted, 0);
    chk("mrst_land_y", land_y, 0);
    chk("mrst_land_idx", land_idx, 0);
    seen = 1'b0;
    repeat (10) begin
      tick();
      seen |= done | busy;
    end
    chk("mrst_no_done", seen, 0);
    scan("post_rst");
    res("post_rst", 1, 20, 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
